// File: rtl/legv8_mem_access_unit_pkg.sv
// Shared definitions for the LEGv8 data-memory access unit: FSM state
// encoding, default widths and the wait-counter load helper.
package legv8_mem_access_unit_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 32;
    localparam int MEM_LATENCY_DEF = 1;

    // Wait counter width; supports MEM_LATENCY values up to 256.
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // A read beat lasts MEM_LATENCY cycles; the counter reaches zero on the
    // last of them, so it is loaded with latency-1.
    function automatic logic [CNT_W-1:0] wait_load_val(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/legv8_mem_access_unit_wait_ctr.sv
// Loadable down-counter that times a read beat; o_done is high while the
// count is zero, i.e. during the last cycle of the beat.
module legv8_mem_wait_ctr
    import legv8_mem_access_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    // Count register: load has priority, otherwise decrement toward zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != {CNT_W{1'b0}})) begin
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_done = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/legv8_mem_access_unit.sv
// Initiator side of the Data_Memory port. Turns MEM-stage load/store
// requests into one or two memory beats (32-bit or 64-bit access) and
// returns load data / store completion through a held response register.
module legv8_mem_access_unit
    import legv8_mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_double,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_rdata,
    output logic                  read_data_flag,
    output logic                  write_data_flag,
    output logic [ADDR_W-1:0]     address_of_data,
    output logic [DATA_W-1:0]     data_to_write,
    input  logic [DATA_W-1:0]     data_read_out
);

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [2*DATA_W-1:0]   r_rsp_rdata;
    logic                  r_read_flag;
    logic                  r_write_flag;
    logic [ADDR_W-1:0]     r_address;
    logic [DATA_W-1:0]     r_data_to_write;
    logic                  r_double;
    logic [DATA_W-1:0]     r_wdata_hi;
    logic [DATA_W-1:0]     r_rdata_lo;

    logic                  w_accept;
    logic                  w_ctr_load;
    logic                  w_ctr_en;
    logic                  w_ctr_done;
    logic [CNT_W-1:0]      w_ctr_load_val;

    // req_ready is only ever high in IDLE, so it alone qualifies the accept.
    assign w_accept       = req_valid & r_req_ready;
    assign w_ctr_load_val = wait_load_val(MEM_LATENCY);

    assign req_ready       = r_req_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign read_data_flag  = r_read_flag;
    assign write_data_flag = r_write_flag;
    assign address_of_data = r_address;
    assign data_to_write   = r_data_to_write;

    // Wait-counter control: arm at the start of each read beat, count down while the beat runs.
    always_comb begin
        w_ctr_load = 1'b0;
        w_ctr_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !req_write) begin
                    w_ctr_load = 1'b1;
                end else begin
                    w_ctr_load = 1'b0;
                end
            end
            ST_RD_LO: begin
                if (w_ctr_done) begin
                    w_ctr_load = r_double;
                end else begin
                    w_ctr_en = 1'b1;
                end
            end
            ST_RD_HI: begin
                if (w_ctr_done) begin
                    w_ctr_en = 1'b0;
                end else begin
                    w_ctr_en = 1'b1;
                end
            end
            default: begin
                w_ctr_load = 1'b0;
                w_ctr_en   = 1'b0;
            end
        endcase
    end

    legv8_mem_wait_ctr u_wait_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_ctr_load),
        .i_load_val (w_ctr_load_val),
        .i_en       (w_ctr_en),
        .o_done     (w_ctr_done)
    );

    // Main FSM with request capture, memory-side drive and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_req_ready     <= 1'b1;
            r_rsp_valid     <= 1'b0;
            r_rsp_rdata     <= {(2*DATA_W){1'b0}};
            r_read_flag     <= 1'b0;
            r_write_flag    <= 1'b0;
            r_address       <= {ADDR_W{1'b0}};
            r_data_to_write <= {DATA_W{1'b0}};
            r_double        <= 1'b0;
            r_wdata_hi      <= {DATA_W{1'b0}};
            r_rdata_lo      <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_double    <= req_double;
                        r_wdata_hi  <= req_wdata[2*DATA_W-1:DATA_W];
                        r_address   <= req_addr;
                        if (req_write) begin
                            r_write_flag    <= 1'b1;
                            r_data_to_write <= req_wdata[DATA_W-1:0];
                            r_state         <= ST_WR_LO;
                        end else begin
                            r_read_flag <= 1'b1;
                            r_state     <= ST_RD_LO;
                        end
                    end
                end
                ST_RD_LO: begin
                    if (w_ctr_done) begin
                        if (r_double) begin
                            // Keep read_data_flag high and step to the high word (wraps at the top).
                            r_rdata_lo <= data_read_out;
                            r_address  <= r_address + ADDR_W'(1);
                            r_state    <= ST_RD_HI;
                        end else begin
                            r_read_flag <= 1'b0;
                            r_rsp_rdata <= {{DATA_W{1'b0}}, data_read_out};
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_RD_HI: begin
                    if (w_ctr_done) begin
                        r_read_flag <= 1'b0;
                        r_rsp_rdata <= {data_read_out, r_rdata_lo};
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_WR_LO: begin
                    if (r_double) begin
                        r_address       <= r_address + ADDR_W'(1);
                        r_data_to_write <= r_wdata_hi;
                        r_state         <= ST_WR_HI;
                    end else begin
                        r_write_flag <= 1'b0;
                        r_rsp_rdata  <= {(2*DATA_W){1'b0}};
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_WR_HI: begin
                    r_write_flag <= 1'b0;
                    r_rsp_rdata  <= {(2*DATA_W){1'b0}};
                    r_rsp_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    // A request seen in the handshake cycle waits for IDLE.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_rsp_valid  <= 1'b0;
                    r_read_flag  <= 1'b0;
                    r_write_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_mem_access_unit.sv
// Bench for legv8_mem_access_unit with a behavioural Data_Memory
// (preloaded mem[i]=i) and a transaction-level reference model.
module tb_legv8_mem_access_unit;

    localparam int ML = 1;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_double;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        read_data_flag;
    logic        write_data_flag;
    logic [7:0]  address_of_data;
    logic [31:0] data_to_write;
    logic [31:0] data_read_out;

    legv8_mem_access_unit #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .MEM_LATENCY (ML)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_double      (req_double),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .read_data_flag  (read_data_flag),
        .write_data_flag (write_data_flag),
        .address_of_data (address_of_data),
        .data_to_write   (data_to_write),
        .data_read_out   (data_read_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data_Memory: combinational read, write on the rising edge.
    logic [31:0] mem [0:255];
    assign data_read_out = mem[address_of_data];
    always @(posedge clk) begin
        if (write_data_flag) mem[address_of_data] <= data_to_write;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of the unit.
    logic [31:0] ref_mem [0:255];
    logic        m_started = 1'b0;
    logic        m_ready, m_busy, m_resp, m_write, m_double;
    logic [7:0]  m_base;
    logic [63:0] m_wdata, m_rdata;
    int          m_elapsed, m_total;
    int          m_acc_cnt = 0;

    task automatic model_step();
        logic [7:0] a1;
        m_started = 1'b1;
        if (!rst_n) begin
            m_ready = 1'b1; m_busy = 1'b0; m_resp = 1'b0;
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_resp  = 1'b0;
                m_ready = 1'b1;
            end
        end else if (m_busy) begin
            m_elapsed++;
            if (m_elapsed == m_total) begin
                m_busy = 1'b0;
                m_resp = 1'b1;
            end
        end else if (m_ready && req_valid) begin
            m_acc_cnt++;
            m_ready   = 1'b0;
            m_busy    = 1'b1;
            m_write   = req_write;
            m_double  = req_double;
            m_base    = req_addr;
            m_wdata   = req_wdata;
            m_elapsed = 0;
            a1        = req_addr + 8'd1;
            m_total   = (req_double ? 2 : 1) * (req_write ? 1 : ML);
            if (req_write) begin
                ref_mem[req_addr] = req_wdata[31:0];
                if (req_double) ref_mem[a1] = req_wdata[63:32];
                m_rdata = 64'd0;
            end else begin
                m_rdata = {req_double ? ref_mem[a1] : 32'd0, ref_mem[req_addr]};
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare of every DUT output against the model.
    int wf_cnt = 0;
    initial begin
        int         beat;
        logic [7:0] ea;
        forever begin
            @(negedge clk);
            if (m_started) begin
                if (write_data_flag) wf_cnt++;
                chk("flags_exclusive", 64'(read_data_flag & write_data_flag), 64'd0);
                chk("req_ready", 64'(req_ready), 64'(m_ready));
                chk("rsp_valid", 64'(rsp_valid), 64'(m_resp));
                if (m_resp) chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("read_data_flag", 64'(read_data_flag), 64'(m_busy && !m_write));
                chk("write_data_flag", 64'(write_data_flag), 64'(m_busy && m_write));
                if (m_busy) begin
                    beat = m_elapsed / (m_write ? 1 : ML);
                    ea   = m_base + 8'(beat);
                    chk("address_of_data", 64'(address_of_data), 64'(ea));
                    if (m_write)
                        chk("data_to_write", 64'(data_to_write),
                            64'(beat == 0 ? m_wdata[31:0] : m_wdata[63:32]));
                end
            end
        end
    end

    // rsp_ready source: 0 = random, otherwise held by the main sequence.
    int rr_mode = 2;
    always @(negedge clk) begin
        if (rr_mode == 0) rsp_ready = 1'($urandom_range(0, 1));
    end

    // Present a request and hold it until the model says it was accepted.
    task automatic issue(input logic w, input logic d, input logic [7:0] a, input logic [63:0] wd);
        int acc0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_double = d; req_addr = a; req_wdata = wd;
        acc0 = m_acc_cnt;
        for (int i = 0; i < 200 && m_acc_cnt == acc0; i++) @(negedge clk);
        if (m_acc_cnt == acc0) chk("accept_timeout", 64'd1, 64'd0);
        // Scramble the fields after acceptance: the unit must have captured them.
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_double = 1'($urandom_range(0, 1));
        req_addr = 8'($urandom);
        req_wdata = {$urandom, $urandom};
    endtask

    // Called on the negedge right after the accept edge; lat counts the accept cycle.
    task automatic finish_rsp(output logic [63:0] rd, output int lat);
        int n;
        n = 1;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", 64'd1, 64'd0);
        rd  = rsp_rdata;
        lat = n;
    endtask

    task automatic txn(input logic w, input logic d, input logic [7:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output int lat);
        issue(w, d, a, wd);
        finish_rsp(rd, lat);
    endtask

    initial begin
        logic [63:0] rd;
        int          lat;
        logic        w, d;
        logic [7:0]  a, a1;
        logic [63:0] wd;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_double = 1'b0;
        req_addr = 8'd0; req_wdata = 64'd0; rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset held 2 cycles in the middle of a 64-bit load: no response.
        issue(1'b0, 1'b1, 8'h40, 64'd0);
        chk("pre_reset_read_flag", 64'(read_data_flag), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_read_flag", 64'(read_data_flag), 64'd0);
        chk("rst_write_flag", 64'(write_data_flag), 64'd0);
        rst_n = 1'b1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
        end

        // 32-bit load of preloaded word.
        txn(1'b0, 1'b0, 8'h10, 64'd0, rd, lat);
        chk("ld32_rdata", rd, 64'h10);
        chk("ld32_latency", 64'(lat), 64'd2);

        // 64-bit store, then read back.
        wf_cnt = 0;
        txn(1'b1, 1'b1, 8'h20, 64'hDEADBEEF_12345678, rd, lat);
        chk("st64_latency", 64'(lat), 64'd3);
        chk("st64_rdata", rd, 64'd0);
        repeat (2) @(negedge clk);
        chk("st64_wflag_cycles", 64'(wf_cnt), 64'd2);
        chk("st64_mem_lo", 64'(mem[8'h20]), 64'h12345678);
        chk("st64_mem_hi", 64'(mem[8'h21]), 64'hDEADBEEF);
        txn(1'b0, 1'b1, 8'h20, 64'd0, rd, lat);
        chk("ld64_rdata", rd, 64'hDEADBEEF_12345678);
        chk("ld64_latency", 64'(lat), 64'd3);

        // High-word address wraps 255 -> 0.
        txn(1'b0, 1'b1, 8'hFF, 64'd0, rd, lat);
        chk("ld64_wrap_rdata", rd, 64'h00000000_000000FF);

        // Backpressure: response held, then a request in the handshake cycle.
        repeat (2) @(negedge clk);
        rr_mode = 1; rsp_ready = 1'b0;
        txn(1'b0, 1'b0, 8'h33, 64'd0, rd, lat);
        chk("bp_rdata", rd, 64'h33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_rdata", rsp_rdata, 64'h33);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rr_mode = 2; rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_double = 1'b0; req_addr = 8'h34;
        @(negedge clk);
        chk("bp_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("bp_hs_req_ready", 64'(req_ready), 64'd1);
        chk("bp_hs_no_read", 64'(read_data_flag), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_next_req_ready", 64'(req_ready), 64'd0);
        chk("bp_next_read", 64'(read_data_flag), 64'd1);
        chk("bp_next_addr", 64'(address_of_data), 64'h34);
        finish_rsp(rd, lat);
        chk("bp_next_rdata", rd, 64'h34);
        chk("bp_next_latency", 64'(lat), 64'd2);

        // Randomised traffic with random response backpressure.
        rr_mode = 0;
        for (int k = 0; k < 200; k++) begin
            w  = 1'($urandom_range(0, 1));
            d  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            wd = {$urandom, $urandom};
            txn(w, d, a, wd, rd, lat);
            if (w) begin
                a1 = a + 8'd1;
                chk("rand_mem_lo", 64'(mem[a]), 64'(ref_mem[a]));
                if (d) chk("rand_mem_hi", 64'(mem[a1]), 64'(ref_mem[a1]));
            end
        end

        // Sweep: store 5 everywhere with 32-bit stores, then read all back.
        rr_mode = 2; rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) txn(1'b1, 1'b0, 8'(i), 64'd5, rd, lat);
        for (int i = 0; i < 256; i++) begin
            txn(1'b0, 1'b0, 8'(i), 64'd0, rd, lat);
            chk("sweep_rdata", rd, 64'd5);
        end

        for (int i = 0; i < 50 && !m_ready; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
